// File: rtl/time_set_ctrl_pkg.sv
// rtl/time_set_ctrl_pkg.sv - shared state encoding and BCD limit constants for the time-set controller
package time_set_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    // Largest legal value of each BCD pair, split into tens (Z) and units (U).
    localparam int HOUR_MAX_Z = 2;
    localparam int HOUR_MAX_U = 3;
    localparam int MIN_MAX_Z  = 5;
    localparam int MIN_MAX_U  = 9;

    // Largest legal units digit in any BCD position.
    localparam int BCD_MAX = 9;

endpackage

// File: rtl/bcd_pair_inc.sv
// rtl/bcd_pair_inc.sv - combinational wrap-around increment of one tens/units BCD pair
module bcd_pair_inc
    import time_set_ctrl_pkg::*;
#(
    parameter int Z_W   = 2,
    parameter int MAX_Z = 2,
    parameter int MAX_U = 3
) (
    input  logic [Z_W-1:0] z_in,
    input  logic [3:0]     u_in,
    output logic [Z_W-1:0] z_out,
    output logic [3:0]     u_out
);

    localparam logic [Z_W-1:0] Z_LIM = Z_W'(MAX_Z);
    localparam logic [3:0]     U_LIM = 4'(MAX_U);
    localparam logic [3:0]     U_TOP = 4'(BCD_MAX);

    logic u_bad;
    logic z_bad;
    logic pair_bad;
    logic at_max;

    // Any illegal pair, or the top legal value, wraps to 00; otherwise BCD +1 with carry.
    always_comb begin
        u_bad    = (u_in > U_TOP);
        z_bad    = (z_in > Z_LIM);
        pair_bad = (z_in == Z_LIM) && (u_in > U_LIM);
        at_max   = (z_in == Z_LIM) && (u_in == U_LIM);
        z_out    = z_in;
        u_out    = u_in + 4'd1;
        if (u_bad || z_bad || pair_bad || at_max) begin
            z_out = '0;
            u_out = '0;
        end else if (u_in == U_TOP) begin
            z_out = z_in + Z_W'(1);
            u_out = '0;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven hour/minute editor that loads the edited time into the counter
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 30,
    parameter int REPEAT_DLY     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic [3:0] u_min_cur,
    input  logic [2:0] z_min_cur,
    input  logic [3:0] u_hour_cur,
    input  logic [1:0] z_hour_cur,
    output logic [3:0] u_min_out,
    output logic [2:0] z_min_out,
    output logic [3:0] u_hour_out,
    output logic [1:0] z_hour_out,
    output logic       load,
    output logic       edit_hour,
    output logic       edit_min
);

    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HOLD_W = $clog2(REPEAT_DLY + 1);

    // The timeout fires on the cycle the counter has already seen TIMEOUT_CYCLES-1 idle cycles.
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(REPEAT_DLY);

    state_t             state;
    state_t             state_next;
    logic               set_q;
    logic               inc_q;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_next;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_next;
    logic               set_ev;
    logic               inc_ev;
    logic               repeat_tick;
    logic               do_capture;
    logic               do_hour_inc;
    logic               do_min_inc;
    logic [3:0]         u_hour_nx;
    logic [1:0]         z_hour_nx;
    logic [3:0]         u_min_nx;
    logic [2:0]         z_min_nx;

    bcd_pair_inc #(
        .Z_W   (2),
        .MAX_Z (HOUR_MAX_Z),
        .MAX_U (HOUR_MAX_U)
    ) u_hour_inc (
        .z_in  (z_hour_out),
        .u_in  (u_hour_out),
        .z_out (z_hour_nx),
        .u_out (u_hour_nx)
    );

    bcd_pair_inc #(
        .Z_W   (3),
        .MAX_Z (MIN_MAX_Z),
        .MAX_U (MIN_MAX_U)
    ) u_min_inc (
        .z_in  (z_min_out),
        .u_in  (u_min_out),
        .z_out (z_min_nx),
        .u_out (u_min_nx)
    );

    // Rising-edge events; holding INC past REPEAT_DLY cycles produces one extra event per cycle.
    always_comb begin
        repeat_tick = btn_inc && (hold_cnt == HOLD_SAT);
        set_ev      = btn_set && !set_q;
        inc_ev      = (btn_inc && !inc_q) || repeat_tick;
        hold_next   = '0;
        if (btn_inc) begin
            hold_next = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + HOLD_W'(1);
        end
    end

    // Previous button levels and the saturating INC hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_q    <= 1'b0;
            inc_q    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            set_q    <= btn_set;
            inc_q    <= btn_inc;
            hold_cnt <= hold_next;
        end
    end

    // State and idle-timeout registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_next;
            tmo_cnt <= tmo_next;
        end
    end

    // Next state, timeout bookkeeping and edit actions; SET beats INC in the same cycle.
    always_comb begin
        state_next  = state;
        tmo_next    = tmo_cnt;
        do_capture  = 1'b0;
        do_hour_inc = 1'b0;
        do_min_inc  = 1'b0;
        case (state)
            IDLE: begin
                tmo_next = '0;
                if (set_ev) begin
                    do_capture = 1'b1;
                    state_next = SET_HOUR;
                end
            end
            SET_HOUR: begin
                if (set_ev) begin
                    state_next = SET_MIN;
                    tmo_next   = '0;
                end else if (inc_ev) begin
                    do_hour_inc = 1'b1;
                    tmo_next    = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = IDLE;
                    tmo_next   = '0;
                end else begin
                    tmo_next = tmo_cnt + TMO_W'(1);
                end
            end
            SET_MIN: begin
                if (set_ev) begin
                    state_next = COMMIT;
                    tmo_next   = '0;
                end else if (inc_ev) begin
                    do_min_inc = 1'b1;
                    tmo_next   = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next = IDLE;
                    tmo_next   = '0;
                end else begin
                    tmo_next = tmo_cnt + TMO_W'(1);
                end
            end
            COMMIT: begin
                state_next = IDLE;
                tmo_next   = '0;
            end
            default: begin
                state_next = IDLE;
                tmo_next   = '0;
            end
        endcase
    end

    // Edit registers double as the outputs; they move only on capture or increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_min_out  <= '0;
            z_min_out  <= '0;
            u_hour_out <= '0;
            z_hour_out <= '0;
        end else if (do_capture) begin
            u_min_out  <= u_min_cur;
            z_min_out  <= z_min_cur;
            u_hour_out <= u_hour_cur;
            z_hour_out <= z_hour_cur;
        end else if (do_hour_inc) begin
            u_hour_out <= u_hour_nx;
            z_hour_out <= z_hour_nx;
        end else if (do_min_inc) begin
            u_min_out  <= u_min_nx;
            z_min_out  <= z_min_nx;
        end
    end

    // Registered state decode so load and the blink selects line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load      <= 1'b0;
            edit_hour <= 1'b0;
            edit_min  <= 1'b0;
        end else begin
            load      <= (state_next == COMMIT);
            edit_hour <= (state_next == SET_HOUR);
            edit_min  <= (state_next == SET_MIN);
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - randomized and directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

    localparam int TO = 30;
    localparam int RD = 3;

    logic       clk;
    logic       rst;
    logic       btn_set;
    logic       btn_inc;
    logic [3:0] u_min_cur;
    logic [2:0] z_min_cur;
    logic [3:0] u_hour_cur;
    logic [1:0] z_hour_cur;
    logic [3:0] u_min_out;
    logic [2:0] z_min_out;
    logic [3:0] u_hour_out;
    logic [1:0] z_hour_out;
    logic       load;
    logic       edit_hour;
    logic       edit_min;

    int tests;
    int fails;
    int load_cnt;

    // model: 0 idle, 1 editing hours, 2 editing minutes, 3 committing
    int m_state;
    int m_zh, m_uh, m_zm, m_um;
    int m_idle;
    int m_run;
    bit m_pset;
    bit s_ev, i_ev;
    int v;

    time_set_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .REPEAT_DLY     (RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_set    (btn_set),
        .btn_inc    (btn_inc),
        .u_min_cur  (u_min_cur),
        .z_min_cur  (z_min_cur),
        .u_hour_cur (u_hour_cur),
        .z_hour_cur (z_hour_cur),
        .u_min_out  (u_min_out),
        .z_min_out  (z_min_out),
        .u_hour_out (u_hour_out),
        .z_hour_out (z_hour_out),
        .load       (load),
        .edit_hour  (edit_hour),
        .edit_min   (edit_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hour_next(input int z, input int u);
        int val;
        val = z * 10 + u;
        if (u > 9 || val >= 23) return 0;
        return val + 1;
    endfunction

    function automatic int min_next(input int z, input int u);
        if (u > 9 || z > 5) return 0;
        return (z * 10 + u + 1) % 60;
    endfunction

    // Behavioural reference, advanced once per clock from the sampled button levels.
    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_zh = 0; m_uh = 0; m_zm = 0; m_um = 0;
            m_idle = 0;
            m_run = 0;
            m_pset = 1'b0;
        end else begin
            s_ev = btn_set && !m_pset;
            i_ev = btn_inc && (m_run == 0 || m_run >= RD);
            case (m_state)
                0: begin
                    if (s_ev) begin
                        m_zh = int'(z_hour_cur); m_uh = int'(u_hour_cur);
                        m_zm = int'(z_min_cur);  m_um = int'(u_min_cur);
                        m_state = 1;
                        m_idle = 0;
                    end
                end
                1, 2: begin
                    if (s_ev) begin
                        m_state = m_state + 1;
                        m_idle = 0;
                    end else if (i_ev) begin
                        if (m_state == 1) begin
                            v = hour_next(m_zh, m_uh);
                            m_zh = v / 10; m_uh = v % 10;
                        end else begin
                            v = min_next(m_zm, m_um);
                            m_zm = v / 10; m_um = v % 10;
                        end
                        m_idle = 0;
                    end else begin
                        m_idle = m_idle + 1;
                        if (m_idle >= TO) begin
                            m_state = 0;
                            m_idle = 0;
                        end
                    end
                end
                default: m_state = 0;
            endcase
            m_pset = btn_set;
            m_run = btn_inc ? m_run + 1 : 0;
        end
    end

    // Every-cycle comparison of the DUT against the model, clear of the clock edge.
    always @(posedge clk) begin
        #2;
        check("digits", {19'd0, z_hour_out, u_hour_out, z_min_out, u_min_out},
              (m_zh << 11) | (m_uh << 7) | (m_zm << 4) | m_um);
        check("load", {31'd0, load}, (m_state == 3) ? 1 : 0);
        check("edit_hour", {31'd0, edit_hour}, (m_state == 1) ? 1 : 0);
        check("edit_min", {31'd0, edit_min}, (m_state == 2) ? 1 : 0);
        if (load === 1'b1) load_cnt++;
    end

    task automatic press_set();
        @(negedge clk); btn_set = 1'b1;
        @(negedge clk); btn_set = 1'b0;
    endtask

    task automatic press_inc();
        @(negedge clk); btn_inc = 1'b1;
        @(negedge clk); btn_inc = 1'b0;
    endtask

    task automatic set_cur(input int zh, input int uh, input int zm, input int um);
        z_hour_cur = 2'(zh); u_hour_cur = 4'(uh);
        z_min_cur  = 3'(zm); u_min_cur  = 4'(um);
    endtask

    task automatic check_time(input string name, input int zh, input int uh, input int zm, input int um);
        check(name, {19'd0, z_hour_out, u_hour_out, z_min_out, u_min_out},
              (zh << 11) | (uh << 7) | (zm << 4) | um);
    endtask

    int lc0;
    int set_rate;

    initial begin
        tests = 0; fails = 0; load_cnt = 0;
        rst = 1'b1; btn_set = 1'b0; btn_inc = 1'b0;
        set_cur(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check_time("reset_digits", 0, 0, 0, 0);
        check("reset_flags", {29'd0, load, edit_hour, edit_min}, 0);
        rst = 1'b0;

        // full set from 22:58
        set_cur(2, 2, 5, 8);
        press_set();
        check("fs_edit_hour", {31'd0, edit_hour}, 1);
        check_time("fs_capture", 2, 2, 5, 8);
        press_inc();
        check_time("fs_hour_23", 2, 3, 5, 8);
        press_set();
        press_inc();
        check_time("fs_min_59", 2, 3, 5, 9);
        press_set();
        check("fs_load", {31'd0, load}, 1);
        check_time("fs_load_time", 2, 3, 5, 9);
        @(negedge clk);
        check("fs_load_one_cycle", {31'd0, load}, 0);

        // both fields wrap, no carry from minutes into hours
        set_cur(2, 3, 5, 9);
        press_set();
        press_inc();
        check_time("wrap_hour", 0, 0, 5, 9);
        press_set();
        press_inc();
        press_set();
        check("wrap_load", {31'd0, load}, 1);
        check_time("wrap_load_time", 0, 0, 0, 0);

        // auto-repeat: 6 held cycles from 10 -> 14
        set_cur(1, 2, 1, 0);
        press_set();
        press_set();
        check("rep_edit_min", {31'd0, edit_min}, 1);
        @(negedge clk); btn_inc = 1'b1;
        repeat (6) @(negedge clk);
        btn_inc = 1'b0;
        check_time("rep_min_14", 1, 2, 1, 4);
        press_set();
        check("rep_load", {31'd0, load}, 1);

        // simultaneous SET and INC, then reset mid-edit
        set_cur(0, 8, 4, 4);
        press_set();
        @(negedge clk); btn_set = 1'b1; btn_inc = 1'b1;
        @(negedge clk); btn_set = 1'b0; btn_inc = 1'b0;
        check("sim_edit_min", {31'd0, edit_min}, 1);
        check_time("sim_hour_08", 0, 8, 4, 4);
        @(negedge clk); rst = 1'b1;
        #1;
        check_time("mid_rst_digits", 0, 0, 0, 0);
        check("mid_rst_flags", {29'd0, load, edit_hour, edit_min}, 0);
        @(negedge clk); rst = 1'b0;
        lc0 = load_cnt;
        repeat (5) @(negedge clk);
        check("mid_rst_no_load", load_cnt, lc0);

        // out-of-range hour 27 then timeout
        set_cur(2, 7, 3, 3);
        press_set();
        press_inc();
        check_time("oor_hour_00", 0, 0, 3, 3);
        lc0 = load_cnt;
        repeat (TO - 1) @(negedge clk);
        check("tmo_still_edit", {31'd0, edit_hour}, 1);
        @(negedge clk);
        check("tmo_idle", {30'd0, edit_hour, edit_min}, 0);
        check("tmo_no_load", load_cnt, lc0);

        // randomized phase, model compared every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            set_rate = (i < 1500) ? 9 : 39;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if ($urandom_range(0, set_rate) == 0) btn_set = ~btn_set;
            if ($urandom_range(0, 4) == 0) btn_inc = ~btn_inc;
            if ($urandom_range(0, 15) == 0) begin
                z_hour_cur = 2'($urandom_range(0, 3));
                u_hour_cur = 4'($urandom_range(0, 15));
                z_min_cur  = 3'($urandom_range(0, 7));
                u_min_cur  = 4'($urandom_range(0, 15));
            end
        end
        btn_set = 1'b0; btn_inc = 1'b0; rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
